// File: rtl/wb_reg_bank_pkg.sv
// Shared address-map constants, state types and decode helper for wb_reg_bank.
package wb_reg_bank_pkg;

  localparam int unsigned ID_ADDR       = 0;
  localparam int unsigned STATUS_OFFSET = 0;
  localparam logic        UNMAPPED_BIT  = 1'b0;

  typedef enum logic [1:0] {
    REGION_ID,
    REGION_RW,
    REGION_STATUS,
    REGION_NONE
  } region_e;

  typedef enum logic {
    ST_OPEN,
    ST_HOLD
  } stall_state_e;

  // Status sits directly above the register window.
  function automatic region_e decode_addr(input logic [31:0] addr, input int unsigned num_regs);
    if (addr == ID_ADDR) return REGION_ID;
    if (addr < num_regs) return REGION_RW;
    if (addr == num_regs + STATUS_OFFSET) return REGION_STATUS;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/wb_reg_bank_if.sv
// Pipelined Wishbone slave bus bundle for wb_reg_bank.
interface wb_reg_bank_if #(
  parameter int unsigned BYTES     = 1,
  parameter int unsigned ADDR_BITS = 8
);

  logic [ADDR_BITS-1:0] addr;
  logic [BYTES*8-1:0]   dat_m2s;
  logic [BYTES*8-1:0]   dat_s2m;
  logic                 we;
  logic [BYTES-1:0]     sel;
  logic                 stb;
  logic                 cyc;
  logic                 ack;
  logic                 stall;

  modport master (
    output addr, dat_m2s, we, sel, stb, cyc,
    input  dat_s2m, ack, stall
  );

  modport slave (
    input  addr, dat_m2s, we, sel, stb, cyc,
    output dat_s2m, ack, stall
  );

endinterface

// File: rtl/wb_ack_pipe.sv
// Fixed-depth valid+data delay line with synchronous flush, used for ack/read data.
module wb_ack_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!sresetn || flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dat_q[0] <= in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/wb_reg_bank.sv
// Wishbone-pipelined register bank: RO ID at 0, RW window, RO status above it.
module wb_reg_bank
  import wb_reg_bank_pkg::*;
#(
  parameter int unsigned        BYTES           = 1,
  parameter int unsigned        ADDR_BITS       = 8,
  parameter int unsigned        NUM_REGS        = 16,
  parameter int unsigned        ACK_LATENCY     = 1,
  parameter bit                 STALL_ALTERNATE = 1'b0,
  parameter logic [BYTES*8-1:0] ID_VALUE        = 8'hA5
) (
  input  logic                         clk,
  input  logic                         sresetn,
  wb_reg_bank_if.slave                 s_wb,
  output logic [NUM_REGS*BYTES*8-1:0]  regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o,
  input  logic [BYTES*8-1:0]           status_i
);

  localparam int unsigned DW = BYTES * 8;

  logic [ADDR_BITS-1:0] addr;
  logic                 accept;
  region_e              region;
  logic [DW-1:0]        rd_data;
  logic [DW-1:0]        push_data;
  logic [NUM_REGS-1:0]  wr_hit;
  logic [DW-1:0]        regs_q [1:NUM_REGS-1];
  stall_state_e         state_q;
  stall_state_e         state_d;
  logic                 ack_vld;
  logic [DW-1:0]        ack_dat;

  assign addr   = s_wb.addr;
  assign accept = sresetn && s_wb.cyc && s_wb.stb && !s_wb.stall;
  assign region = decode_addr(32'(addr), NUM_REGS);

  always_comb begin
    wr_hit = '0;
    for (int unsigned n = 1; n < NUM_REGS; n++) begin
      wr_hit[n] = accept && s_wb.we && (32'(addr) == n);
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      wr_pulse_o <= '0;
      for (int unsigned n = 1; n < NUM_REGS; n++) begin
        regs_q[n] <= '0;
      end
    end else begin
      wr_pulse_o <= wr_hit;
      for (int unsigned n = 1; n < NUM_REGS; n++) begin
        for (int unsigned b = 0; b < BYTES; b++) begin
          if (wr_hit[n] && s_wb.sel[b]) begin
            regs_q[n][8*b +: 8] <= s_wb.dat_m2s[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = {DW{UNMAPPED_BIT}};
    unique case (region)
      REGION_ID:     rd_data = ID_VALUE;
      REGION_STATUS: rd_data = status_i;
      REGION_RW: begin
        for (int unsigned n = 1; n < NUM_REGS; n++) begin
          if (32'(addr) == n) rd_data = regs_q[n];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    regs_o        = '0;
    regs_o[DW-1:0] = ID_VALUE;
    for (int unsigned n = 1; n < NUM_REGS; n++) begin
      regs_o[n*DW +: DW] = regs_q[n];
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) state_q <= ST_OPEN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_OPEN;
    if (STALL_ALTERNATE && accept) state_d = ST_HOLD;
  end

  assign s_wb.stall = sresetn && (state_q == ST_HOLD);

  // Write beats carry zero so the returned data is zero for write acks.
  assign push_data = s_wb.we ? '0 : rd_data;

  wb_ack_pipe #(
    .DEPTH (ACK_LATENCY),
    .WIDTH (DW)
  ) u_ack_pipe (
    .clk       (clk),
    .sresetn   (sresetn),
    .flush     (!s_wb.cyc),
    .in_valid  (accept),
    .in_data   (push_data),
    .out_valid (ack_vld),
    .out_data  (ack_dat)
  );

  // Masking with cyc drops an ack already at the pipe output when cyc falls.
  assign s_wb.ack     = ack_vld && s_wb.cyc && sresetn;
  assign s_wb.dat_s2m = s_wb.ack ? ack_dat : '0;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed-vector bench: three wb_reg_bank instances (latency 1, 3, 4+alternate stall).
module tb_wb_reg_bank;

  logic       clk = 1'b0;
  logic       sresetn;
  logic [7:0] status;

  logic       cyc_d  [3];
  logic       stb_d  [3];
  logic       we_d   [3];
  logic       sel_d  [3];
  logic [7:0] addr_d [3];
  logic [7:0] dat_d  [3];

  logic         ack_w   [3];
  logic         stall_w [3];
  logic [7:0]   dat_w   [3];
  logic [127:0] regs_w  [3];
  logic [15:0]  pulse_w [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_reg_bank_if #(.BYTES(1), .ADDR_BITS(8)) bus ();

    assign bus.cyc     = cyc_d[g];
    assign bus.stb     = stb_d[g];
    assign bus.we      = we_d[g];
    assign bus.sel     = sel_d[g];
    assign bus.addr    = addr_d[g];
    assign bus.dat_m2s = dat_d[g];
    assign ack_w[g]    = bus.ack;
    assign stall_w[g]  = bus.stall;
    assign dat_w[g]    = bus.dat_s2m;

    wb_reg_bank #(
      .BYTES           (1),
      .ADDR_BITS       (8),
      .NUM_REGS        (16),
      .ACK_LATENCY     ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .STALL_ALTERNATE (g == 2),
      .ID_VALUE        (8'hA5)
    ) dut (
      .clk        (clk),
      .sresetn    (sresetn),
      .s_wb       (bus),
      .regs_o     (regs_w[g]),
      .wr_pulse_o (pulse_w[g]),
      .status_i   (status)
    );
  end

  typedef struct {
    logic        rstn;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  dat;
    logic        sel;
    logic        ack;
    logic [7:0]  edat;
    logic        stall;
    logic [15:0] pulse;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push(input logic rstn, input logic cyc, input logic stb, input logic we,
                               input logic [7:0] addr, input logic [7:0] dat, input logic sel,
                               input logic ack, input logic [7:0] edat, input logic stall,
                               input logic [15:0] pulse);
    vec_t t;
    t.rstn = rstn; t.cyc = cyc; t.stb = stb; t.we = we; t.addr = addr; t.dat = dat;
    t.sel = sel; t.ack = ack; t.edat = edat; t.stall = stall; t.pulse = pulse;
    vq.push_back(t);
  endfunction

  function automatic void rd(input logic [7:0] a, input logic ack, input logic [7:0] ed,
                             input logic st, input logic [15:0] p);
    push(1'b1, 1'b1, 1'b1, 1'b0, a, 8'h00, 1'b0, ack, ed, st, p);
  endfunction

  function automatic void wr(input logic [7:0] a, input logic [7:0] d, input logic sel,
                             input logic ack, input logic [7:0] ed, input logic st,
                             input logic [15:0] p);
    push(1'b1, 1'b1, 1'b1, 1'b1, a, d, sel, ack, ed, st, p);
  endfunction

  function automatic void gap(input logic cyc, input logic ack, input logic [7:0] ed,
                              input logic st, input logic [15:0] p);
    push(1'b1, cyc, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ack, ed, st, p);
  endfunction

  // Each vector is driven just after a rising edge and checked on the following falling edge.
  task automatic run(input string tag, input int k);
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      sresetn   = vq[i].rstn;
      cyc_d[k]  = vq[i].cyc;
      stb_d[k]  = vq[i].stb;
      we_d[k]   = vq[i].we;
      addr_d[k] = vq[i].addr;
      dat_d[k]  = vq[i].dat;
      sel_d[k]  = vq[i].sel;
      @(negedge clk);
      check($sformatf("%s[%0d].ack", tag, i),   ack_w[k],   vq[i].ack);
      check($sformatf("%s[%0d].dat", tag, i),   dat_w[k],   vq[i].edat);
      check($sformatf("%s[%0d].stall", tag, i), stall_w[k], vq[i].stall);
      check($sformatf("%s[%0d].pulse", tag, i), pulse_w[k], vq[i].pulse);
    end
    vq.delete();
  endtask

  initial begin
    sresetn = 1'b0;
    status  = 8'h77;
    for (int k = 0; k < 3; k++) begin
      cyc_d[k] = 1'b0; stb_d[k] = 1'b0; we_d[k] = 1'b0;
      sel_d[k] = 1'b0; addr_d[k] = 8'h00; dat_d[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d.ack", k),   ack_w[k],   1'b0);
      check($sformatf("reset%0d.stall", k), stall_w[k], 1'b0);
      check($sformatf("reset%0d.dat", k),   dat_w[k],   8'h00);
      check($sformatf("reset%0d.pulse", k), pulse_w[k], 16'h0000);
      check($sformatf("reset%0d.regs", k),  regs_w[k],  128'hA5);
    end

    // Release reset with a write already presented: accepted at the first edge out of reset.
    sresetn   = 1'b1;
    cyc_d[0]  = 1'b1; stb_d[0] = 1'b1; we_d[0] = 1'b1;
    addr_d[0] = 8'd2; dat_d[0] = 8'h3C; sel_d[0] = 1'b1;
    gap(1'b1, 1'b1, 8'h00, 1'b0, 16'h0004);
    gap(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    run("wr_addr2", 0);
    check("wr_addr2.slot2", regs_w[0][23:16], 8'h3C);

    // ID, status, RO/unmapped writes, sel=0 write, unmapped reads.
    rd(8'd0,               1'b0, 8'h00, 1'b0, 16'h0000);
    rd(8'd16,              1'b1, 8'hA5, 1'b0, 16'h0000);
    wr(8'd0, 8'h11, 1'b1,  1'b1, 8'h77, 1'b0, 16'h0000);
    wr(8'd17, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000);
    rd(8'd17,              1'b1, 8'h00, 1'b0, 16'h0000);
    wr(8'd16, 8'hEE, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000);
    wr(8'd3, 8'hFF, 1'b0,  1'b1, 8'h00, 1'b0, 16'h0000);
    rd(8'd200,             1'b1, 8'h00, 1'b0, 16'h0008);
    rd(8'd2,               1'b1, 8'h00, 1'b0, 16'h0000);
    gap(1'b1,              1'b1, 8'h3C, 1'b0, 16'h0000);
    gap(1'b1,              1'b0, 8'h00, 1'b0, 16'h0000);
    run("map", 0);
    check("map.regs", regs_w[0], 128'h3C00A5);

    // Latency 3: write then read of the same address back to back.
    wr(8'd5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    rd(8'd5,              1'b0, 8'h00, 1'b0, 16'h0020);
    gap(1'b1,             1'b0, 8'h00, 1'b0, 16'h0000);
    gap(1'b1,             1'b1, 8'h00, 1'b0, 16'h0000);
    gap(1'b1,             1'b1, 8'h5A, 1'b0, 16'h0000);
    gap(1'b1,             1'b0, 8'h00, 1'b0, 16'h0000);
    run("lat3", 1);
    check("lat3.slot5", regs_w[1][47:40], 8'h5A);

    // Alternate stall with strobe held: each beat is re-presented until accepted.
    wr(8'd1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    rd(8'd1,              1'b0, 8'h00, 1'b1, 16'h0002);
    rd(8'd1,              1'b0, 8'h00, 1'b0, 16'h0000);
    rd(8'd0,              1'b0, 8'h00, 1'b1, 16'h0000);
    rd(8'd0,              1'b1, 8'h00, 1'b0, 16'h0000);
    rd(8'd16,             1'b0, 8'h00, 1'b1, 16'h0000);
    rd(8'd16,             1'b1, 8'h11, 1'b0, 16'h0000);
    gap(1'b1,             1'b0, 8'h00, 1'b1, 16'h0000);
    gap(1'b1,             1'b1, 8'hA5, 1'b0, 16'h0000);
    gap(1'b1,             1'b0, 8'h00, 1'b0, 16'h0000);
    gap(1'b1,             1'b1, 8'h77, 1'b0, 16'h0000);
    gap(1'b1,             1'b0, 8'h00, 1'b0, 16'h0000);
    run("stall", 2);

    // Drop cyc with two writes in flight: no acks, writes persist.
    wr(8'd3, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    wr(8'd4, 8'h44, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0008);
    wr(8'd4, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    gap(1'b0,             1'b0, 8'h00, 1'b1, 16'h0010);
    gap(1'b0,             1'b0, 8'h00, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) gap(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    run("flush", 2);
    check("flush.regs", regs_w[2], 128'h44330011A5);

    // Reset mid-burst on the latency-3 instance.
    push(1'b1, 1'b1, 1'b1, 1'b1, 8'd6, 8'h66, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    push(1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0040);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    run("rst", 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst.regs%0d", k),  regs_w[k],  128'hA5);
      check($sformatf("rst.stall%0d", k), stall_w[k], 1'b0);
    end

    rd(8'd0,  1'b0, 8'h00, 1'b0, 16'h0000);
    gap(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    gap(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    gap(1'b1, 1'b1, 8'hA5, 1'b0, 16'h0000);
    gap(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
    run("post_rst", 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_reg_bank.md
WB_REG_BANK -- requirements
Module: wb_reg_bank

Interface
REQ-001 Parameter BYTES, default 1: Wishbone data width in bytes.
REQ-002 Parameter ADDR_BITS, default 8: Wishbone address width.
REQ-003 Parameter NUM_REGS, default 16, range 2..2**ADDR_BITS-1: size of register window (address 0 to NUM_REGS-1).
REQ-004 Parameter ACK_LATENCY, default 1, range 1..4: cycles from beat acceptance to ack.
REQ-005 Parameter STALL_ALTERNATE, default 0: 1 = assert stall the cycle after every accepted beat.
REQ-006 Parameter ID_VALUE, default 8'hA5 (zero-extended to BYTES*8): read-only contents of address 0.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 sresetn  input  1  reset, synchronous, active-low.
REQ-009 s_wb_addr  input  ADDR_BITS  word address.
REQ-010 s_wb_dat_m2s  input  BYTES*8  write data.
REQ-011 s_wb_dat_s2m  output  BYTES*8  read data, valid only with ack.
REQ-012 s_wb_we  input  1  1 = write beat.
REQ-013 s_wb_sel  input  BYTES  per-byte write enable; bit i gates bits 8i+7:8i.
REQ-014 s_wb_stb, s_wb_cyc  input  1 each  pipelined Wishbone strobe and cycle.
REQ-015 s_wb_ack, s_wb_stall  output  1 each  acknowledge, stall.
REQ-016 regs_o  output  NUM_REGS*BYTES*8  flat register contents, register n at bits n*BYTES*8 upward; slot 0 carries ID_VALUE.
REQ-017 wr_pulse_o  output  NUM_REGS  one-cycle pulse per register on accepted write to it.
REQ-018 status_i  input  BYTES*8  read-only value mapped at address NUM_REGS.

Function
REQ-019 Beat accepted when s_wb_cyc && s_wb_stb && !s_wb_stall; at most one per cycle.
REQ-020 Address map: 0 = ID (RO); 1..NUM_REGS-1 = RW; NUM_REGS = status_i (RO); all others read 0, writes ignored.
REQ-021 Accepted write to RW address updates selected bytes at the accepting edge; visible on regs_o next cycle; wr_pulse_o[addr] high for that next cycle only.
REQ-022 Writes to RO or unmapped addresses change no state, raise no wr_pulse_o, and are still acked.
REQ-023 Read data sampled at the accepting edge from current register/status_i values; a read accepted the cycle after a write to the same address returns the new value.
REQ-024 Every accepted beat (read or write) produces exactly one ack, exactly ACK_LATENCY cycles after acceptance (ACK_LATENCY=1: ack in the cycle after the accept edge); acks of back-to-back beats are back-to-back, in order.
REQ-025 s_wb_dat_s2m = read data when ack with read beat, else 0.
REQ-026 STALL_ALTERNATE=0: s_wb_stall constantly 0. STALL_ALTERNATE=1: stall high for exactly the cycle after each accepted beat, otherwise 0 (max one beat per two cycles).
REQ-027 s_wb_cyc low: all in-flight acks discarded (pipeline flushed); no ack issued while cyc is low; register writes already accepted remain.
REQ-028 s_wb_sel all zero on write: no bytes change, wr_pulse_o still pulses, ack issued.

Reset
REQ-029 While sresetn low: RW registers 0, ack pipeline empty, s_wb_ack 0, s_wb_stall 0, s_wb_dat_s2m 0, wr_pulse_o 0; in-flight beats are dropped without ack.
REQ-030 First beat can be accepted in the first cycle sresetn is high.

Structure
REQ-031 Address-map constants (ID address 0, status offset, unmapped read value 0) in shared package wb_reg_bank_pkg.
REQ-032 Ack/read-data delay line implemented as sub-module wb_ack_pipe (parameters DEPTH, WIDTH; valid+data shift with synchronous flush).

Verification
REQ-033 Write 0x3C to addr 2, sel=1, ACK_LATENCY=1 -> ack one cycle later, regs_o slot 2 = 0x3C, wr_pulse_o[2] one cycle.
REQ-034 Write addr 5 then read addr 5 in consecutive cycles, ACK_LATENCY=3 -> acks at cycles +3 and +4, read returns written value.
REQ-035 Read addr 0 and addr NUM_REGS with status_i=0x77 -> 0xA5 then 0x77; write to addr 0 -> acked, ID unchanged, no pulse.
REQ-036 STALL_ALTERNATE=1, 4 back-to-back strobes held -> stall pattern 0,1,0,1,..., exactly 4 acks, order preserved.
REQ-037 Drop cyc with 2 beats in flight (ACK_LATENCY=4) -> no acks; accepted writes persist.
REQ-038 Assert sresetn low mid-burst -> all regs 0, no ack, stall 0; transaction after release completes normally.
